fifo_uart_tx: RTL and testbench
===============================

Name: fifo_uart_tx

Overview:
- Downstream consumer of the 4-entry, 8-bit byte FIFO.
- Pops one byte at a time through the FIFO read interface and serialises it as an 8N1 UART frame (optional even parity) on `tx`.
- Respects the FIFO's one-cycle registered read latency: `dout` is valid in the cycle after `rd_en`.
- Sits between the FIFO and the chip-level serial pin.

Parameters:
- CLKS_PER_BIT, 4, clock cycles per serial bit; legal range is >= 2.
- PARITY_EN, 0, 1 inserts an even-parity bit between data bit 7 and the stop bit.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- tx_en  input  1  transmit enable; sampled only in IDLE.
- fifo_empty  input  1  FIFO empty flag.
- fifo_rd_en  output  1  FIFO read strobe; one-cycle pulse per byte.
- fifo_dout  input  8  FIFO read data; valid the cycle after fifo_rd_en.
- tx  output  1  serial line; idles high.
- busy  output  1  high whenever state != IDLE.
- frames_sent  output  16  count of completed frames; wraps modulo 2^16.

Behaviour:

Reset (asynchronous, immediate):
- tx=1, busy=0, fifo_rd_en=0, frames_sent=0.
- state=IDLE; bit counter and baud counter cleared.

Outputs:
- All outputs are registered or pure decodes of registered state; there is no combinational input-to-output path.
- fifo_rd_en = (state==FETCH).
- tx is the registered line value.

States and transitions:
- IDLE: tx=1. If tx_en && !fifo_empty, go to FETCH next cycle; otherwise stay.
- FETCH: exactly 1 cycle; fifo_rd_en=1. Always go to LOAD.
- LOAD: exactly 1 cycle; shift register <= fifo_dout; parity <= ^fifo_dout. Go to START.
- START: tx=0 for CLKS_PER_BIT cycles. Go to DATA.
- DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles; 3-bit index runs 0..7. After bit 7, go to PARITY if PARITY_EN, else STOP.
- PARITY: tx = XOR of the 8 data bits (even parity) for CLKS_PER_BIT cycles. Go to STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles. On the final cycle, frames_sent += 1. Go to IDLE.

Baud counter:
- Width is $clog2(CLKS_PER_BIT).
- Reloads to 0 on every bit boundary and on entry to START.
- A bit ends when the counter reaches CLKS_PER_BIT-1.

Frame timing:
- tx falls on the 3rd clock edge after the IDLE cycle that saw the request (IDLE -> FETCH -> LOAD -> START).
- Frame length is (10 + PARITY_EN) * CLKS_PER_BIT cycles.
- Back-to-back frames have a fixed 3-cycle high gap (IDLE + FETCH + LOAD) between the end of the stop bit and the next start bit.

Boundary conditions:
- tx_en deasserted mid-frame: the current frame completes; no new pop occurs.
- fifo_empty rising while in FETCH or later: ignored; the popped byte is still sent.
- At most one pop per frame; fifo_rd_en is never asserted while fifo_empty=1 in IDLE.
- Reset mid-frame: tx returns high immediately. The popped byte is lost; the FIFO is not notified.
- frames_sent wraps from 0xFFFF to 0x0000 without saturating.

Test Plan:
1. CLKS_PER_BIT=4, PARITY_EN=0, FIFO holds 0xA5, tx_en=1
   -> fifo_rd_en high for exactly 1 cycle
   -> tx bit sequence is 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles wide (40 cycles total)
   -> frames_sent=1, busy low afterwards.
2. PARITY_EN=1, bytes 0x07 then 0xA5
   -> parity bits are 1 and 0 respectively
   -> frames are 44 cycles each with exactly 3 high cycles between them
   -> frames_sent=2.
3. fifo_empty=1 throughout, tx_en=1 for 100 cycles
   -> fifo_rd_en never asserted, tx stays 1, busy stays 0.
4. FIFO holds 4 bytes; drop tx_en during data bit 3 of the first frame
   -> first frame completes, no further fifo_rd_en pulse, frames_sent=1.
   -> Re-assert tx_en -> the remaining 3 bytes are sent in order.
5. Assert rst_n low during the DATA state
   -> tx=1, busy=0, frames_sent=0 in the same cycle.
   -> After release with a non-empty FIFO, a fresh frame starts with a full-width start bit.
6. Preload frames_sent near wrap (e.g. via 65535 short frames with CLKS_PER_BIT=2) and send one more
   -> frames_sent reads 0x0000.

Source files
------------

// File: rtl/fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// fifo_uart_tx
//
// Purpose:
//   Drains a byte FIFO one entry at a time and serialises each byte as a UART
//   frame on `tx`: one start bit (0), eight data bits LSB first, an optional
//   even-parity bit, and one stop bit (1). Every bit is held for CLKS_PER_BIT
//   clock cycles. The FIFO has a one-cycle registered read, so the byte popped
//   in FETCH is captured in the following LOAD cycle.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per serial bit; must be 2 or more.
//   PARITY_EN     1 inserts an even-parity bit between data bit 7 and stop.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   tx_en        in   transmit enable, only looked at while IDLE
//   fifo_empty   in   FIFO empty flag
//   fifo_rd_en   out  one-cycle FIFO pop strobe per frame
//   fifo_dout    in   FIFO read data, valid the cycle after fifo_rd_en
//   tx           out  registered serial line, idles high
//   busy         out  high whenever the FSM is not IDLE
//   frames_sent  out  completed-frame counter, wraps modulo 2^16
//
// FIFO read handshake: a pop is requested by holding fifo_rd_en high for
// exactly one cycle while the FIFO reported non-empty on the cycle before;
// the FIFO presents the popped byte on fifo_dout in the next cycle. There is
// no back-pressure from the FIFO side and at most one pop per frame.
// -----------------------------------------------------------------------------
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tx_en,
  input  logic        fifo_empty,
  output logic        fifo_rd_en,
  input  logic [7:0]  fifo_dout,
  output logic        tx,
  output logic        busy,
  output logic [15:0] frames_sent
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_LOAD   = 3'd2,
    S_START  = 3'd3,
    S_DATA   = 3'd4,
    S_PARITY = 3'd5,
    S_STOP   = 3'd6
  } state_e;

  state_e              state_q, state_d;
  logic [BAUD_W-1:0]   baud_q,  baud_d;
  logic [2:0]          bit_q,   bit_d;
  logic [7:0]          shift_q, shift_d;
  logic                parity_q, parity_d;
  logic                tx_q,    tx_d;
  logic [15:0]         frames_q, frames_d;
  logic                bit_end;

  // Last cycle of the current serial bit.
  assign bit_end = (baud_q == BAUD_LAST);

  // ---------------------------------------------------------------------------
  // Next-state and datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    frames_d = frames_q;
    tx_d     = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (tx_en && !fifo_empty) begin
          state_d = S_FETCH;
        end
      end

      S_FETCH: begin
        state_d = S_LOAD;
      end

      S_LOAD: begin
        shift_d  = fifo_dout;
        parity_d = ^fifo_dout;
        baud_d   = '0;
        state_d  = S_START;
      end

      S_START: begin
        if (bit_end) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      S_DATA: begin
        if (bit_end) begin
          baud_d  = '0;
          // Next data bit always sits in shift_q[0].
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      S_PARITY: begin
        if (bit_end) begin
          baud_d  = '0;
          state_d = S_STOP;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      S_STOP: begin
        if (bit_end) begin
          baud_d   = '0;
          frames_d = frames_q + 16'd1;
          state_d  = S_IDLE;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
        baud_d  = '0;
      end
    endcase

    // The line is registered from the state being entered, so tx changes on
    // the same edge as the state and stays aligned with the baud counter.
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = parity_d;
      default:  tx_d = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= 3'd0;
      shift_q  <= 8'd0;
      parity_q <= 1'b0;
      tx_q     <= 1'b1;
      frames_q <= 16'd0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      tx_q     <= tx_d;
      frames_q <= frames_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: registers or decodes of registered state only
  // ---------------------------------------------------------------------------
  assign fifo_rd_en  = (state_q == S_FETCH);
  assign busy        = (state_q != S_IDLE);
  assign tx          = tx_q;
  assign frames_sent = frames_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_fifo_uart_tx
//
// Two transmitters share clock and reset: u_dut0 without parity and u_dut1
// with even parity, both at 4 clocks per bit. Each has its own small FIFO
// model with a one-cycle registered read. Only one transmitter is active at a
// time, so a single expected-frame queue serves both; every entry is tagged
// with the instance it belongs to.
// -----------------------------------------------------------------------------
module tb_fifo_uart_tx;

  localparam int CPB = 4;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------------------
  // DUT wiring
  // ---------------------------------------------------------------------------
  logic [1:0]  tx_en_w;
  logic [1:0]  empty_w = 2'b11;
  logic [1:0]  rd_w;
  logic [1:0]  tx_w;
  logic [1:0]  busy_w;
  logic [7:0]  dout0 = 8'h00;
  logic [7:0]  dout1 = 8'h00;
  logic [15:0] frames0, frames1;

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(0)) u_dut0 (
    .clk         (clk),
    .rst_n       (rst_n),
    .tx_en       (tx_en_w[0]),
    .fifo_empty  (empty_w[0]),
    .fifo_rd_en  (rd_w[0]),
    .fifo_dout   (dout0),
    .tx          (tx_w[0]),
    .busy        (busy_w[0]),
    .frames_sent (frames0)
  );

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1)) u_dut1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .tx_en       (tx_en_w[1]),
    .fifo_empty  (empty_w[1]),
    .fifo_rd_en  (rd_w[1]),
    .fifo_dout   (dout1),
    .tx          (tx_w[1]),
    .busy        (busy_w[1]),
    .frames_sent (frames1)
  );

  // ---------------------------------------------------------------------------
  // FIFO models (registered read) and pop counters
  // ---------------------------------------------------------------------------
  logic [7:0] mem0[$];
  logic [7:0] mem1[$];
  int rd_cnt0 = 0;
  int rd_cnt1 = 0;

  always @(posedge clk) begin
    if (rd_w[0] && mem0.size() > 0) dout0 <= mem0.pop_front();
    if (rd_w[1] && mem1.size() > 0) dout1 <= mem1.pop_front();
    empty_w[0] <= (mem0.size() == 0);
    empty_w[1] <= (mem1.size() == 0);
    if (rd_w[0]) rd_cnt0 <= rd_cnt0 + 1;
    if (rd_w[1]) rd_cnt1 <= rd_cnt1 + 1;
  end

  // ---------------------------------------------------------------------------
  // Scoreboard
  // Entry: {back_to_back, instance, stop, parity, data[7:0]}
  // ---------------------------------------------------------------------------
  logic [11:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic push_byte(input int g, input logic [7:0] b);
    if (g == 0) mem0.push_back(b);
    else        mem1.push_back(b);
  endtask

  task automatic expect_frame(input int g, input logic [7:0] b, input logic par,
                              input logic b2b);
    exp_q.push_back({b2b, g[0], 1'b1, par, b});
  endtask

  // Monitor: finds a start bit on tx, samples every cycle of every bit,
  // rebuilds the frame and compares it with the head of the queue.
  task automatic watch(input int g);
    int          nbits;
    int          last_end;
    int          gap;
    logic        aborted;
    logic        width_ok;
    logic [10:0] bits;
    logic [11:0] exp_e;
    logic [10:0] got;
    nbits    = (g == 1) ? 11 : 10;
    last_end = -1000;
    forever begin
      @(negedge clk);
      if (rst_n && !tx_w[g]) begin
        gap      = cyc - last_end - 1;
        aborted  = 1'b0;
        width_ok = 1'b1;
        bits     = '0;
        for (int b = 0; b < nbits; b++) begin
          for (int c = 0; c < CPB; c++) begin
            if (b != 0 || c != 0) @(negedge clk);
            if (!rst_n) aborted = 1'b1;
            if (c == 0) bits[b] = tx_w[g];
            else if (tx_w[g] != bits[b]) width_ok = 1'b0;
          end
          if (aborted) break;
        end
        if (exp_q.size() == 0) begin
          chk("unexpected_frame", 32'd0, 32'd1);
        end else begin
          exp_e = exp_q.pop_front();
          // A frame cut by reset is dropped along with its popped byte.
          if (!aborted) begin
            last_end = cyc;
            got = {g[0], bits[nbits-1], (g == 1) ? bits[9] : 1'b0, bits[8:1]};
            chk("frame", {21'd0, got}, {21'd0, exp_e[10:0]});
            chk("bit_width", {31'd0, width_ok}, 32'd1);
            if (exp_e[11]) chk("b2b_gap", gap, 32'd3);
          end
        end
      end
    end
  endtask

  initial watch(0);
  initial watch(1);

  // ---------------------------------------------------------------------------
  // Driver helpers
  // ---------------------------------------------------------------------------
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_done(input int max);
    int n = 0;
    while ((exp_q.size() != 0 || busy_w != 2'b00) && n < max) begin
      @(negedge clk);
      n++;
    end
    chk("done_timeout", {31'd0, (n < max)}, 32'd1);
    repeat (4) @(negedge clk);
  endtask

  // Returns the number of negedges until tx of instance g goes low.
  task automatic wait_start(input int g, output int lat);
    lat = 0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (!tx_w[g]) break;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int lat;
    int rd_base;
    int viol;

    rst_n   = 1'b0;
    tx_en_w = 2'b00;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_tx",     {30'd0, tx_w},   32'h3);
    chk("rst_busy",   {30'd0, busy_w}, 32'h0);
    chk("rst_rd_en",  {30'd0, rd_w},   32'h0);
    chk("rst_frames0", {16'd0, frames0}, 32'h0);
    chk("rst_frames1", {16'd0, frames1}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Test 1: single byte 0xA5, no parity
    rd_base = rd_cnt0;
    push_byte(0, 8'hA5);
    expect_frame(0, 8'hA5, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    tx_en_w[0] = 1'b1;
    wait_start(0, lat);
    chk("t1_start_latency", lat, 32'd3);
    chk("t1_busy_in_frame", {31'd0, busy_w[0]}, 32'd1);
    wait_done(200);
    chk("t1_rd_pulses", rd_cnt0 - rd_base, 32'd1);
    chk("t1_frames", {16'd0, frames0}, 32'd1);
    chk("t1_busy_after", {31'd0, busy_w[0]}, 32'd0);
    chk("t1_tx_idle", {31'd0, tx_w[0]}, 32'd1);

    // Test 3: enabled but FIFO empty for 100 cycles
    rd_base = rd_cnt0;
    viol    = 0;
    repeat (100) begin
      @(negedge clk);
      if (rd_w[0] || !tx_w[0] || busy_w[0]) viol++;
    end
    chk("t3_idle_violations", viol, 32'd0);
    chk("t3_rd_pulses", rd_cnt0 - rd_base, 32'd0);
    tx_en_w[0] = 1'b0;

    // Test 4: drop tx_en during data bit 3, then resume
    do_reset();
    rd_base = rd_cnt0;
    push_byte(0, 8'h11);
    push_byte(0, 8'h22);
    push_byte(0, 8'h33);
    push_byte(0, 8'h44);
    expect_frame(0, 8'h11, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    tx_en_w[0] = 1'b1;
    wait_start(0, lat);
    chk("t4_start_latency", lat, 32'd3);
    repeat (4 * CPB + 1) @(negedge clk);
    tx_en_w[0] = 1'b0;
    wait_done(200);
    repeat (20) @(negedge clk);
    chk("t4_rd_after_drop", rd_cnt0 - rd_base, 32'd1);
    chk("t4_frames_after_drop", {16'd0, frames0}, 32'd1);
    chk("t4_busy_after_drop", {31'd0, busy_w[0]}, 32'd0);
    expect_frame(0, 8'h22, 1'b0, 1'b0);
    expect_frame(0, 8'h33, 1'b0, 1'b1);
    expect_frame(0, 8'h44, 1'b0, 1'b1);
    tx_en_w[0] = 1'b1;
    wait_done(600);
    chk("t4_rd_total", rd_cnt0 - rd_base, 32'd4);
    chk("t4_frames_total", {16'd0, frames0}, 32'd4);
    tx_en_w[0] = 1'b0;

    // Test 5: reset in the middle of the data bits
    push_byte(0, 8'h3C);
    expect_frame(0, 8'h3C, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    tx_en_w[0] = 1'b1;
    wait_start(0, lat);
    repeat (2 * CPB + 1) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_tx", {31'd0, tx_w[0]}, 32'd1);
    chk("t5_rst_busy", {31'd0, busy_w[0]}, 32'd0);
    chk("t5_rst_frames", {16'd0, frames0}, 32'd0);
    chk("t5_rst_rd_en", {31'd0, rd_w[0]}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    push_byte(0, 8'h81);
    expect_frame(0, 8'h81, 1'b0, 1'b0);
    wait_done(200);
    chk("t5_frames_after", {16'd0, frames0}, 32'd1);
    tx_en_w[0] = 1'b0;

    // Test 6: counter wrap from 0xFFFF
    @(negedge clk);
    force u_dut0.frames_q = 16'hFFFF;
    @(negedge clk);
    release u_dut0.frames_q;
    @(negedge clk);
    push_byte(0, 8'h55);
    expect_frame(0, 8'h55, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    tx_en_w[0] = 1'b1;
    wait_done(200);
    chk("t6_frames_wrap", {16'd0, frames0}, 32'd0);
    tx_en_w[0] = 1'b0;

    // Test 2: even parity, 0x07 (parity 1) then 0xA5 (parity 0)
    rd_base = rd_cnt1;
    push_byte(1, 8'h07);
    push_byte(1, 8'hA5);
    expect_frame(1, 8'h07, 1'b1, 1'b0);
    expect_frame(1, 8'hA5, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    tx_en_w[1] = 1'b1;
    wait_start(1, lat);
    chk("t2_start_latency", lat, 32'd3);
    wait_done(400);
    chk("t2_rd_pulses", rd_cnt1 - rd_base, 32'd2);
    chk("t2_frames", {16'd0, frames1}, 32'd2);
    chk("t2_dut0_quiet", {16'd0, frames0}, 32'd0);
    tx_en_w[1] = 1'b0;

    repeat (5) @(negedge clk);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global time limit
  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "simulation time limit");
  end

endmodule
